// File: rtl/ddr_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit DDR port among NumPorts requesters, with an in-order read tag FIFO.
// Optional DDR_ARB_STATS_EN adds per-port grant counters and a stall-cycle counter.
module ddr_rr_arbiter #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MaxOutstanding = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumPorts-1:0]    req_valid_i,
  output logic [NumPorts-1:0]    req_ready_o,
  input  logic [NumPorts*32-1:0] req_addr_i,
  input  logic [NumPorts-1:0]    req_we_i,
  input  logic [NumPorts*64-1:0] req_wdata_i,
  input  logic [NumPorts*8-1:0]  req_be_i,
  output logic [63:0]            rsp_data_o,
  output logic [NumPorts-1:0]    rsp_valid_o,
  output logic [31:0]            mem_addr_o,
  output logic [63:0]            mem_data_o,
  output logic                   mem_write_en_o,
  output logic                   mem_read_en_o,
  output logic [7:0]             mem_byte_en_o,
  input  logic [63:0]            mem_data_i,
  input  logic                   mem_data_valid_i,
  output logic                   err_o
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [NumPorts*32-1:0] grant_cnt_o,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam int unsigned TagW = $clog2(NumPorts);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [TagW:0] NumPortsW = (TagW + 1)'(NumPorts);

  logic [TagW-1:0] r_rr_ptr;
  logic [TagW-1:0] r_tag_mem [MaxOutstanding];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_err;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic [NumPorts-1:0] w_eligible;
  logic [NumPorts-1:0] w_ready;
  logic                w_gnt_valid;
  logic [TagW-1:0]     w_gnt_idx;
  logic [TagW-1:0]     w_next_ptr;
  logic [TagW:0]       w_sum;
  logic [TagW-1:0]     w_idx;
  logic [31:0]         w_sel_addr;
  logic                w_sel_we;
  logic [63:0]         w_sel_wdata;
  logic [7:0]          w_sel_be;
  logic [NumPorts-1:0] w_rsp_oh;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read may still be granted into a full FIFO when the head pops this cycle.
  always_comb begin
    w_full  = (r_count == CntW'(MaxOutstanding));
    w_empty = (r_count == '0);
    w_pop   = mem_data_valid_i && !w_empty;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      w_eligible[p] = req_valid_i[p] && (req_we_i[p] || !w_full || w_pop);
    end
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_ready     = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (TagW + 1)'(i);
      if (w_sum >= NumPortsW) w_sum = w_sum - NumPortsW;
      w_idx = w_sum[TagW-1:0];
      if (!w_gnt_valid && w_eligible[w_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_idx;
      end
    end
    if (w_gnt_valid) w_ready[w_gnt_idx] = 1'b1;
    w_sum = {1'b0, w_gnt_idx} + 1'b1;
    if (w_sum >= NumPortsW) w_sum = '0;
    w_next_ptr = w_sum[TagW-1:0];
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (w_ready[p]) begin
        w_sel_addr  = req_addr_i[p*32 +: 32];
        w_sel_we    = req_we_i[p];
        w_sel_wdata = req_wdata_i[p*64 +: 64];
        w_sel_be    = req_be_i[p*8 +: 8];
      end
    end
    w_push   = w_gnt_valid && !w_sel_we;
    w_rsp_oh = '0;
    w_rsp_oh[r_tag_mem[r_rd_ptr]] = 1'b1;
  end

  assign req_ready_o = w_ready;
  assign err_o       = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr       <= '0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      mem_write_en_o <= 1'b0;
      mem_read_en_o  <= 1'b0;
      mem_byte_en_o  <= '0;
    end else begin
      mem_write_en_o <= w_gnt_valid && w_sel_we;
      mem_read_en_o  <= w_gnt_valid && !w_sel_we;
      if (w_gnt_valid) begin
        r_rr_ptr      <= w_next_ptr;
        mem_addr_o    <= {w_sel_addr[31:3], 3'b000};
        mem_byte_en_o <= w_sel_we ? w_sel_be : 8'hFF;
        if (w_sel_we) mem_data_o <= w_sel_wdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_gnt_idx;
  end

  // A pop against an empty FIFO is never performed, so push+pop when empty is a plain push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      rsp_data_o  <= '0;
      rsp_valid_o <= '0;
    end else begin
      if (w_push) r_wr_ptr <= inc_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= inc_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      if ((w_gnt_valid && (w_sel_addr[2:0] != 3'b000)) || (mem_data_valid_i && w_empty)) begin
        r_err <= 1'b1;
      end
      if (w_pop) begin
        rsp_data_o  <= mem_data_i;
        rsp_valid_o <= w_rsp_oh;
      end else begin
        rsp_valid_o <= '0;
      end
    end
  end

`ifdef DDR_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (w_ready[p] && (grant_cnt_o[p*32 +: 32] != '1)) begin
          grant_cnt_o[p*32 +: 32] <= grant_cnt_o[p*32 +: 32] + 32'd1;
        end
      end
      if ((|req_valid_i) && !w_gnt_valid) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// Scoreboard bench for ddr_rr_arbiter: directed stimulus, DDR model with configurable latency, decoupled response monitor.
module tb_ddr_rr_arbiter;

  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req_valid_i;
  logic [NP-1:0]   req_ready_o;
  logic [NP*32-1:0] req_addr_i;
  logic [NP-1:0]   req_we_i;
  logic [NP*64-1:0] req_wdata_i;
  logic [NP*8-1:0] req_be_i;
  logic [63:0]     rsp_data_o;
  logic [NP-1:0]   rsp_valid_o;
  logic [31:0]     mem_addr_o;
  logic [63:0]     mem_data_o;
  logic            mem_write_en_o;
  logic            mem_read_en_o;
  logic [7:0]      mem_byte_en_o;
  logic [63:0]     mem_data_i = '0;
  logic            mem_data_valid_i = 1'b0;
  logic            err_o;
`ifdef DDR_ARB_STATS_EN
  logic [NP*32-1:0] grant_cnt_o;
  logic [31:0]      stall_cnt_o;
`endif

  logic        t_valid [NP];
  logic        t_we    [NP];
  logic [31:0] t_addr  [NP];
  logic [63:0] t_wdata [NP];
  logic [7:0]  t_be    [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_valid_i[p]          = t_valid[p];
      req_we_i[p]             = t_we[p];
      req_addr_i[p*32 +: 32]  = t_addr[p];
      req_wdata_i[p*64 +: 64] = t_wdata[p];
      req_be_i[p*8 +: 8]      = t_be[p];
    end
  end

  ddr_rr_arbiter #(.NumPorts(NP), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_en_o(mem_write_en_o),
    .mem_read_en_o(mem_read_en_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_data_i(mem_data_i), .mem_data_valid_i(mem_data_valid_i), .err_o(err_o)
`ifdef DDR_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // DDR contents before any write
  function automatic logic [63:0] ddr_init(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  typedef struct { int port; logic [63:0] data; } exp_t;
  exp_t sb [$];

  typedef struct { int due; logic [63:0] data; } pend_t;
  pend_t pend [$];
  logic [63:0] ddr [logic [31:0]];
  int lat = 1;
  int mcyc = 0;
  logic inj = 1'b0;

  function automatic logic [63:0] ddr_rd(input logic [31:0] a);
    return ddr.exists(a) ? ddr[a] : ddr_init(a);
  endfunction

  always @(posedge clk) begin
    pend_t r;
    logic [63:0] cur;
    #2;
    mcyc++;
    if (!rst_n) begin
      pend.delete();
      mem_data_valid_i = 1'b0;
    end else begin
      mem_data_valid_i = inj;
      if (inj) mem_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
      if (pend.size() > 0 && pend[0].due == mcyc) begin
        r = pend.pop_front();
        mem_data_valid_i = 1'b1;
        mem_data_i = r.data;
      end
      if (mem_write_en_o) begin
        cur = ddr_rd(mem_addr_o);
        for (int b = 0; b < 8; b++) if (mem_byte_en_o[b]) cur[b*8 +: 8] = mem_data_o[b*8 +: 8];
        ddr[mem_addr_o] = cur;
      end
      if (mem_read_en_o) begin
        r.due = mcyc + lat;
        r.data = ddr_rd(mem_addr_o);
        pend.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid_o != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid_o), 64'h0);
      end else begin
        e = sb.pop_front();
        check("rsp_port", 64'(rsp_valid_o), 64'(1) << e.port);
        check("rsp_data", rsp_data_o, e.data);
      end
    end
  end

  int gnt_log [$];
  always @(negedge clk) begin
    if (rst_n) for (int p = 0; p < NP; p++) if (req_valid_i[p] && req_ready_o[p]) gnt_log.push_back(p);
  end

  task automatic expect_rd(input int p, input logic [63:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [63:0] wd,
                       input logic [7:0] be, input logic [63:0] exp);
    bit ok = 0;
    @(posedge clk); #1;
    t_valid[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wdata[p] = wd; t_be[p] = be;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (req_ready_o[p]) begin
        ok = 1;
        if (!we) expect_rd(p, exp);
      end
    end
    if (!ok) check("handshake_timeout", 64'(ok), 64'h1);
    @(posedge clk); #1;
    t_valid[p] = 1'b0;
  endtask

  task automatic stream(input int p, input logic [31:0] base, input int n);
    bit ok;
    @(posedge clk); #1;
    t_valid[p] = 1'b1; t_we[p] = 1'b0; t_addr[p] = base;
    for (int i = 0; i < n; i++) begin
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        if (req_ready_o[p]) begin ok = 1; expect_rd(p, ddr_init(t_addr[p])); end
      end
      if (!ok) check("stream_timeout", 64'(ok), 64'h1);
      @(posedge clk); #1;
      t_addr[p] = t_addr[p] + 32'h8;
    end
    t_valid[p] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    bit pop_seen, done, took;
    for (int p = 0; p < NP; p++) begin
      t_valid[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0; t_be[p] = '0;
    end
    #1;
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("rst_rsp_data", rsp_data_o, 64'h0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'h0);
    check("rst_mem_en", 64'({mem_write_en_o, mem_read_en_o}), 64'h0);
    check("rst_mem_be", 64'(mem_byte_en_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // contention: 8 reads per port, grants must alternate starting at port 0
    gnt_log.delete();
    fork
      stream(0, 32'h0, 8);
      stream(1, 32'h100, 8);
    join
    drain();
    check("contention_grants", 64'(gnt_log.size()), 64'd16);
    for (int i = 0; i < gnt_log.size(); i++) check("contention_order", 64'(gnt_log[i]), 64'(i % 2));
`ifdef DDR_ARB_STATS_EN
    check("stats_grant0", 64'(grant_cnt_o[31:0]), 64'd8);
    check("stats_grant1", 64'(grant_cnt_o[63:32]), 64'd8);
    check("stats_stall", 64'(stall_cnt_o), 64'd0);
`endif

    issue(0, 1'b1, 32'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF, '0);
    issue(0, 1'b0, 32'h40, '0, '0, 64'hDEAD_BEEF_0123_4567);
    drain();
    check("single_read_err", 64'(err_o), 64'h0);

    issue(0, 1'b1, 32'h8, 64'h0, 8'hFF, '0);
    issue(0, 1'b1, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, '0);
    issue(0, 1'b0, 32'h8, '0, '0, 64'h0000_0000_FFFF_FFFF);
    drain();

    // FIFO full: 4 outstanding, latency 16; port 1 writes mid-stall
    lat = 16;
    acc = 0; pop_seen = 0; done = 0;
    @(posedge clk); #1;
    t_valid[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 32'h200;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      took = 0;
      if (mem_data_valid_i && !pop_seen) begin
        pop_seen = 1;
        check("full_accepts_before_pop", 64'(acc), 64'd4);
        check("full_pop_ready", 64'(req_ready_o[0]), 64'h1);
      end else if (!pop_seen && acc >= 4) begin
        check("full_stall_ready", 64'(req_ready_o[0]), 64'h0);
      end
      if (t_valid[1]) check("full_write_accept", 64'(req_ready_o[1]), 64'h1);
      if (req_ready_o[0]) begin
        expect_rd(0, ddr_init(t_addr[0]));
        acc++;
        took = 1;
      end
      @(posedge clk); #1;
      t_valid[1] = 1'b0;
      if (c == 7) begin
        t_valid[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 32'h300;
        t_wdata[1] = 64'h1234_5678_9ABC_DEF0; t_be[1] = 8'hFF;
      end
      if (acc == 6) begin
        t_valid[0] = 1'b0;
        done = 1;
      end else if (took) begin
        t_addr[0] = t_addr[0] + 32'h8;
      end
    end
    check("full_pop_seen", 64'(pop_seen), 64'h1);
    drain();
    lat = 1;

    check("err_before_unaligned", 64'(err_o), 64'h0);
    issue(1, 1'b0, 32'h43, '0, '0, 64'hDEAD_BEEF_0123_4567);
    check("unaligned_addr", 64'(mem_addr_o), 64'h40);
    check("unaligned_rd_en", 64'(mem_read_en_o), 64'h1);
    check("unaligned_be", 64'(mem_byte_en_o), 64'hFF);
    check("unaligned_err", 64'(err_o), 64'h1);
    drain();

    reset_dut();
    check("err_after_reset", 64'(err_o), 64'h0);
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("underflow_no_rsp", 64'(rsp_valid_o), 64'h0);
    end
    check("underflow_err", 64'(err_o), 64'h1);
    check("sb_final_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
